// File: rtl/pipe_regfile_fwd_pkg.sv
// Shared definitions for the forwarding register file: forward source codes,
// pipeline slot records and default parameter values.
package pipe_regfile_fwd_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_ZERO_REG = 1;

  // Where an operand came from: register array or one of the result buses
  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_EX = 2'd1,
    FWD_DM = 2'd2,
    FWD_WB = 2'd3
  } fwd_sel_e;

  // EX slot needs the load flag because a load result is not ready until DM
  typedef struct packed {
    logic valid;
    logic we;
    logic load;
  } ex_slot_t;

  // Once an instruction leaves EX its result is on a bus, so the load flag
  // no longer matters and DM/WB only track whether they will write
  typedef struct packed {
    logic valid;
    logic we;
  } tail_slot_t;

  // A slot supplies the operand when it holds a real writing instruction
  // targeting the register being read, unless that register is hardwired zero
  function automatic logic slotHit(input logic valid, input logic we,
                                   input logic destEq, input logic rsIsZero);
    return valid & we & destEq & ~rsIsZero;
  endfunction

endpackage

// File: rtl/pipe_fwd_mux.sv
// Per-read-port source selection: compares the source register against the
// EX/DM/WB slots and picks imm > EX > DM > WB > register array.
module pipe_fwd_mux
  import pipe_regfile_fwd_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic [ADDR_W-1:0] i_rs,
  input  logic              i_imm_sel,
  input  logic [DATA_W-1:0] i_imm,
  input  ex_slot_t          i_ex_slot,
  input  logic [ADDR_W-1:0] i_ex_dest,
  input  tail_slot_t        i_dm_slot,
  input  logic [ADDR_W-1:0] i_dm_dest,
  input  tail_slot_t        i_wb_slot,
  input  logic [ADDR_W-1:0] i_wb_dest,
  input  logic [DATA_W-1:0] i_rf_data,
  input  logic [DATA_W-1:0] i_ans_ex,
  input  logic [DATA_W-1:0] i_ans_dm,
  input  logic [DATA_W-1:0] i_ans_wb,
  output logic [DATA_W-1:0] o_op,
  output fwd_sel_e          o_sel,
  output logic              o_load_hit
);

  logic w_rsZero;
  logic w_exHit;
  logic w_dmHit;
  logic w_wbHit;

  assign w_rsZero = (ZERO_REG != 0) && (i_rs == '0);
  assign w_exHit  = slotHit(i_ex_slot.valid, i_ex_slot.we, i_ex_dest == i_rs, w_rsZero);
  assign w_dmHit  = slotHit(i_dm_slot.valid, i_dm_slot.we, i_dm_dest == i_rs, w_rsZero);
  assign w_wbHit  = slotHit(i_wb_slot.valid, i_wb_slot.we, i_wb_dest == i_rs, w_rsZero);

  // Youngest producer wins; an immediate hides the register entirely, so a
  // load in EX only matters when this port really reads the register
  always_comb begin
    o_op       = i_rf_data;
    o_sel      = FWD_RF;
    o_load_hit = 1'b0;
    if (i_imm_sel) begin
      o_op = i_imm;
    end else if (w_rsZero) begin
      o_op = '0;
    end else if (w_exHit) begin
      o_op       = i_ans_ex;
      o_sel      = FWD_EX;
      o_load_hit = i_ex_slot.load;
    end else if (w_dmHit) begin
      o_op  = i_ans_dm;
      o_sel = FWD_DM;
    end else if (w_wbHit) begin
      o_op  = i_ans_wb;
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_regfile_fwd.sv
// Register file with EX/DM/WB hazard tracking, operand forwarding and
// load-use stall generation between decode and the ALU stage.
module pipe_regfile_fwd
  import pipe_regfile_fwd_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_dec_valid,
  input  logic [NUM_RD*ADDR_W-1:0] i_rs_addr,
  input  logic [ADDR_W-1:0]        i_rd_addr,
  input  logic                     i_rd_we,
  input  logic                     i_is_load,
  input  logic [DATA_W-1:0]        i_imm,
  input  logic                     i_imm_sel,
  input  logic [DATA_W-1:0]        i_ans_ex,
  input  logic [DATA_W-1:0]        i_ans_dm,
  input  logic [DATA_W-1:0]        i_ans_wb,
  output logic [NUM_RD*DATA_W-1:0] o_op_q,
  output logic [NUM_RD*2-1:0]      o_fwd_sel,
  output logic                     o_stall
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]        r_rf [NUM_REGS];
  ex_slot_t                 r_exSlot;
  logic [ADDR_W-1:0]        r_exDest;
  tail_slot_t               r_dmSlot;
  logic [ADDR_W-1:0]        r_dmDest;
  tail_slot_t               r_wbSlot;
  logic [ADDR_W-1:0]        r_wbDest;
  logic [NUM_RD*DATA_W-1:0] r_opQ;
  logic [NUM_RD*2-1:0]      r_fwdSel;

  logic [NUM_RD*DATA_W-1:0] w_op;
  logic [NUM_RD*2-1:0]      w_sel;
  logic [NUM_RD-1:0]        w_loadHit;
  logic                     w_stall;
  logic                     w_wbWrite;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_port
      logic [ADDR_W-1:0] w_rs;
      logic              w_immSel;
      logic [DATA_W-1:0] w_rfData;
      fwd_sel_e          w_portSel;

      assign w_rs     = i_rs_addr[gi*ADDR_W +: ADDR_W];
      assign w_immSel = (gi == NUM_RD - 1) ? i_imm_sel : 1'b0;
      assign w_rfData = r_rf[w_rs];

      pipe_fwd_mux #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
      ) u_mux (
        .i_rs      (w_rs),
        .i_imm_sel (w_immSel),
        .i_imm     (i_imm),
        .i_ex_slot (r_exSlot),
        .i_ex_dest (r_exDest),
        .i_dm_slot (r_dmSlot),
        .i_dm_dest (r_dmDest),
        .i_wb_slot (r_wbSlot),
        .i_wb_dest (r_wbDest),
        .i_rf_data (w_rfData),
        .i_ans_ex  (i_ans_ex),
        .i_ans_dm  (i_ans_dm),
        .i_ans_wb  (i_ans_wb),
        .o_op      (w_op[gi*DATA_W +: DATA_W]),
        .o_sel     (w_portSel),
        .o_load_hit(w_loadHit[gi])
      );

      assign w_sel[gi*2 +: 2] = w_portSel;
    end
  endgenerate

  assign w_stall   = i_dec_valid & (|w_loadHit);
  assign w_wbWrite = r_wbSlot.valid & r_wbSlot.we & ~((ZERO_REG != 0) && (r_wbDest == '0));

  // Slot pipeline: decode enters EX unless stalled, older slots always advance
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_exSlot <= '0;
      r_exDest <= '0;
      r_dmSlot <= '0;
      r_dmDest <= '0;
      r_wbSlot <= '0;
      r_wbDest <= '0;
    end else begin
      if (w_stall) begin
        r_exSlot <= '0;
        r_exDest <= '0;
      end else begin
        r_exSlot <= '{valid: i_dec_valid, we: i_rd_we, load: i_is_load};
        r_exDest <= i_rd_addr;
      end
      r_dmSlot <= '{valid: r_exSlot.valid, we: r_exSlot.we};
      r_dmDest <= r_exDest;
      r_wbSlot <= r_dmSlot;
      r_wbDest <= r_dmDest;
    end
  end

  // Register array write-back from the WB slot
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        r_rf[k] <= '0;
      end
    end else if (w_wbWrite) begin
      r_rf[r_wbDest] <= i_ans_wb;
    end
  end

  // Operand registers toward EX hold their value while stalled
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_opQ    <= '0;
      r_fwdSel <= '0;
    end else if (!w_stall) begin
      r_opQ    <= w_op;
      r_fwdSel <= w_sel;
    end
  end

  assign o_op_q    = r_opQ;
  assign o_fwd_sel = r_fwdSel;
  assign o_stall   = w_stall;

endmodule

// File: tb/tb_pipe_regfile_fwd.sv
// Directed bench for pipe_regfile_fwd: a default 16-bit/2-port instance and
// a 32-bit/3-port instance sharing clock and reset.
module tb_pipe_regfile_fwd;

  logic        clk;
  logic        rst_n;

  logic        decValid;
  logic [9:0]  rsAddr;
  logic [4:0]  rdAddr;
  logic        rdWe;
  logic        isLoad;
  logic [15:0] imm;
  logic        immSel;
  logic [15:0] ansEx;
  logic [15:0] ansDm;
  logic [15:0] ansWb;
  logic [31:0] opQ;
  logic [3:0]  fwdSel;
  logic        stall;

  logic        d2DecValid;
  logic [14:0] d2RsAddr;
  logic [4:0]  d2RdAddr;
  logic        d2RdWe;
  logic        d2IsLoad;
  logic [31:0] d2Imm;
  logic        d2ImmSel;
  logic [31:0] d2AnsEx;
  logic [31:0] d2AnsDm;
  logic [31:0] d2AnsWb;
  logic [95:0] d2OpQ;
  logic [5:0]  d2FwdSel;
  logic        d2Stall;

  int assertCount;
  int failCount;

  pipe_regfile_fwd #(
    .DATA_W(16), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_dec_valid(decValid), .i_rs_addr(rsAddr),
    .i_rd_addr(rdAddr), .i_rd_we(rdWe), .i_is_load(isLoad), .i_imm(imm),
    .i_imm_sel(immSel), .i_ans_ex(ansEx), .i_ans_dm(ansDm), .i_ans_wb(ansWb),
    .o_op_q(opQ), .o_fwd_sel(fwdSel), .o_stall(stall)
  );

  pipe_regfile_fwd #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(1)
  ) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_dec_valid(d2DecValid), .i_rs_addr(d2RsAddr),
    .i_rd_addr(d2RdAddr), .i_rd_we(d2RdWe), .i_is_load(d2IsLoad), .i_imm(d2Imm),
    .i_imm_sel(d2ImmSel), .i_ans_ex(d2AnsEx), .i_ans_dm(d2AnsDm), .i_ans_wb(d2AnsWb),
    .o_op_q(d2OpQ), .o_fwd_sel(d2FwdSel), .o_stall(d2Stall)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                               input logic [4:0] rd, input logic we, input logic ld);
    decValid = v;
    rsAddr   = {rs1, rs0};
    rdAddr   = rd;
    rdWe     = we;
    isLoad   = ld;
  endtask

  task automatic setAns(input logic [15:0] ex, input logic [15:0] dm, input logic [15:0] wb);
    ansEx = ex;
    ansDm = dm;
    ansWb = wb;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst_n       = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    imm = '0; immSel = 1'b0;
    setAns(16'h0, 16'h0, 16'h0);
    d2DecValid = 1'b0; d2RsAddr = '0; d2RdAddr = '0; d2RdWe = 1'b0; d2IsLoad = 1'b0;
    d2Imm = '0; d2ImmSel = 1'b0; d2AnsEx = '0; d2AnsDm = '0; d2AnsWb = '0;

    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_opq", {32'h0, opQ}, 64'h0);
    checkOutput("reset_fwdsel", {60'h0, fwdSel}, 64'h0);
    checkOutput("reset_stall", {63'h0, stall}, 64'h0);
    checkOutput("reset_d2_opq", {32'h0, d2OpQ[31:0]}, 64'h0);
    stepClock();
    rst_n = 1'b1;

    // ADD r3 then SUB reading r3: EX forward, no stall
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd3, 5'd2, 5'd5, 1'b1, 1'b0);
    setAns(16'h1234, 16'h0, 16'h0);
    #1 checkOutput("exfwd_stall", {63'h0, stall}, 64'h0);
    stepClock();
    checkOutput("exfwd_sel0", {62'h0, fwdSel[1:0]}, 64'd1);
    checkOutput("exfwd_op0", {48'h0, opQ[15:0]}, 64'h1234);
    checkOutput("exfwd_sel1", {62'h0, fwdSel[3:2]}, 64'd0);
    checkOutput("exfwd_op1", {48'h0, opQ[31:16]}, 64'h0);

    // LW r4 reading r5 (SUB in EX), then ADD reading r4: one stall cycle
    applyStimulus(1'b1, 5'd5, 5'd0, 5'd4, 1'b1, 1'b1);
    setAns(16'h0055, 16'h0, 16'h0);
    stepClock();
    checkOutput("lw_src_sel0", {62'h0, fwdSel[1:0]}, 64'd1);
    checkOutput("lw_src_op0", {48'h0, opQ[15:0]}, 64'h0055);
    applyStimulus(1'b1, 5'd4, 5'd0, 5'd6, 1'b1, 1'b0);
    setAns(16'h0, 16'h0, 16'h0);
    #1 checkOutput("loaduse_stall", {63'h0, stall}, 64'h1);
    stepClock();
    checkOutput("stall_hold_op0", {48'h0, opQ[15:0]}, 64'h0055);
    checkOutput("stall_hold_sel0", {62'h0, fwdSel[1:0]}, 64'd1);
    setAns(16'h0, 16'hBEEF, 16'h0);
    #1 checkOutput("after_stall_nostall", {63'h0, stall}, 64'h0);
    stepClock();
    checkOutput("dmfwd_sel0", {62'h0, fwdSel[1:0]}, 64'd2);
    checkOutput("dmfwd_op0", {48'h0, opQ[15:0]}, 64'hBEEF);

    // r7 producer, LW r4 writes back 0x4444 on this edge
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    setAns(16'h0, 16'h0, 16'h4444);
    stepClock();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    setAns(16'h0, 16'h0, 16'h0);
    stepClock();
    stepClock();
    // r7 in WB while decode reads r7 and r4
    applyStimulus(1'b1, 5'd7, 5'd4, 5'd0, 1'b0, 1'b0);
    setAns(16'h0, 16'h0, 16'h00AA);
    stepClock();
    checkOutput("wbfwd_sel0", {62'h0, fwdSel[1:0]}, 64'd3);
    checkOutput("wbfwd_op0", {48'h0, opQ[15:0]}, 64'h00AA);
    checkOutput("rf_r4_sel1", {62'h0, fwdSel[3:2]}, 64'd0);
    checkOutput("rf_r4_op1", {48'h0, opQ[31:16]}, 64'h4444);
    applyStimulus(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
    setAns(16'h0, 16'h0, 16'h0);
    stepClock();
    checkOutput("rf_r7_sel0", {62'h0, fwdSel[1:0]}, 64'd0);
    checkOutput("rf_r7_op0", {48'h0, opQ[15:0]}, 64'h00AA);

    // Write to r0 travels the pipe; every read of r0 stays zero, no forward
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    setAns(16'hFFFF, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      stepClock();
      checkOutput($sformatf("r0_sel0_%0d", i), {62'h0, fwdSel[1:0]}, 64'd0);
      checkOutput($sformatf("r0_op0_%0d", i), {48'h0, opQ[15:0]}, 64'h0);
    end
    setAns(16'h0, 16'h0, 16'h0);

    // Load in EX: bubble never stalls, real reader on either port does
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
    stepClock();
    applyStimulus(1'b0, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0);
    #1 checkOutput("bubble_nostall", {63'h0, stall}, 64'h0);
    applyStimulus(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0);
    #1 checkOutput("loaduse_port0", {63'h0, stall}, 64'h1);
    applyStimulus(1'b1, 5'd0, 5'd4, 5'd0, 1'b0, 1'b0);
    #1 checkOutput("loaduse_port1", {63'h0, stall}, 64'h1);

    // Asynchronous reset mid-stall
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_stall", {63'h0, stall}, 64'h0);
    checkOutput("midrst_opq", {32'h0, opQ}, 64'h0);
    checkOutput("midrst_fwdsel", {60'h0, fwdSel}, 64'h0);
    stepClock();
    rst_n = 1'b1;
    applyStimulus(1'b1, 5'd5, 5'd7, 5'd0, 1'b0, 1'b0);
    stepClock();
    checkOutput("postrst_r5", {48'h0, opQ[15:0]}, 64'h0);
    checkOutput("postrst_r7", {48'h0, opQ[31:16]}, 64'h0);
    checkOutput("postrst_sel", {60'h0, fwdSel}, 64'h0);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // 32-bit, 3 ports: imm on the last port masks a load-use on that port
    d2DecValid = 1'b1; d2RsAddr = {5'd0, 5'd3, 5'd1}; d2RdAddr = 5'd2;
    d2RdWe = 1'b1; d2IsLoad = 1'b1;
    stepClock();
    d2RsAddr = {5'd2, 5'd3, 5'd1}; d2RdAddr = 5'd9; d2RdWe = 1'b1; d2IsLoad = 1'b0;
    d2Imm = 32'hDEADBEEF; d2ImmSel = 1'b0;
    #1 checkOutput("d2_port2_loaduse", {63'h0, d2Stall}, 64'h1);
    d2ImmSel = 1'b1;
    #1 checkOutput("d2_imm_nostall", {63'h0, d2Stall}, 64'h0);
    stepClock();
    checkOutput("d2_imm_op2", {32'h0, d2OpQ[95:64]}, 64'hDEADBEEF);
    checkOutput("d2_imm_sel2", {62'h0, d2FwdSel[5:4]}, 64'd0);
    checkOutput("d2_op0", {32'h0, d2OpQ[31:0]}, 64'h0);
    checkOutput("d2_op1", {32'h0, d2OpQ[63:32]}, 64'h0);
    d2DecValid = 1'b0; d2ImmSel = 1'b0;
    stepClock();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/pipe_regfile_fwd.md
# pipe_regfile_fwd

Parametrised register file with integrated hazard tracking, operand forwarding and load-use stall generation for the pipelined MIPS core. It generalises the current fixed 16-bit, two-read-port register bank and dependency checker pair to configurable data width, register count and read-port count. It sits between decode and the ALU stage: it consumes decoded source/destination fields plus the EX/DM/WB result buses, and delivers registered, hazard-resolved operands and a stall request to the program-memory/stall logic.

## Interface
- DATA_W, 16, operand/result width
- ADDR_W, 5, register address width; register count is 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- dec_valid  in  1  decode slot holds a real instruction
- rs_addr  in  NUM_RD*ADDR_W  source register per port, port i at [i*ADDR_W +: ADDR_W]
- rd_addr  in  ADDR_W  destination of decode instruction
- rd_we  in  1  decode instruction writes rd_addr
- is_load  in  1  decode instruction is a load (result known only after DM)
- imm  in  DATA_W  immediate for the last read port
- imm_sel  in  1  replace last port operand with imm
- ans_ex, ans_dm, ans_wb  in  DATA_W each  result buses of EX, DM, WB slots
- op_q  out  NUM_RD*DATA_W  registered operands for EX
- fwd_sel  out  NUM_RD*2  registered source code per port: 0 RF, 1 EX, 2 DM, 3 WB
- stall  out  1  combinational load-use stall request

## Operation
- Tracks three shadow slots EX, DM, WB, each {valid, we, load, dest}.
- Per port source select, priority order: imm (last port, imm_sel) > EX match > DM match > WB match > RF array. Match = slot valid & we & dest==rs & not (ZERO_REG & rs==0).
- EX match where EX.load=1 is a hazard: stall=1 whenever dec_valid and any port (excluding port overridden by imm) matches a load in EX.
- stall=0: EX<=decode fields (valid=dec_valid), op_q/fwd_sel latch selected values. stall=1: EX<=bubble (valid=0), op_q/fwd_sel hold. DM<=EX, WB<=DM always.
- RF write: at edge, if WB.valid & WB.we & not (ZERO_REG & dest==0): rf[WB.dest]<=ans_wb. Same-cycle read of that register gets ans_wb via WB forward.
- ZERO_REG=1: reads of register 0 return 0 regardless of slots.

## Timing
- Reset (reset=0): all slots invalid, rf all zero, op_q=0, fwd_sel=0, stall=0; takes effect without clock edge; reset mid-stall discards the stalled instruction.
- Operand latency: 1 cycle decode -> op_q.
- Load-use: exactly 1 stall cycle; next cycle the load is in DM and forwards from ans_dm.
- Back-to-back dependent ALU ops: zero stalls (EX forward).
- Multiple slots matching: youngest (EX) wins.
- dec_valid=0 never stalls and inserts a bubble.

## Structure
- Shared package: fwd_sel encodings (FWD_RF, FWD_EX, FWD_DM, FWD_WB), slot record typedef, parameter defaults.
- One natural sub-module: pipe_fwd_mux (one per read port, generate loop) doing slot compare and source priority; top holds rf array, slot pipeline, stall OR-reduction.

## Test plan
- Reset: drive reset=0 mid-run -> op_q=0, fwd_sel=0, stall=0, read of r5 afterwards returns 0.
- ADD r3 then SUB using r3, ans_ex=0x1234 -> port0 fwd_sel=1, op_q[0]=0x1234, stall=0.
- LW r4 then ADD using r4 -> stall=1 one cycle, EX bubble; next cycle fwd_sel=2, op_q=ans_dm=0xBEEF.
- Write r7=0x00AA via WB while decode reads r7 same cycle -> fwd_sel=3, op_q=0x00AA; later read with no slots -> 0x00AA from RF.
- ZERO_REG=1, instruction writes r0=0xFFFF -> subsequent read of r0 gives 0, no forward.
- DATA_W=32, NUM_RD=3, imm_sel=1, imm=0xDEADBEEF while port2 matches load in EX -> no stall, op_q[2]=0xDEADBEEF.
